// File: rtl/adsr_poly.sv
// Multi-voice gate-driven ADSR envelope generator; voices share step/level settings.
// Optional build macro ADSR_EXP_RELEASE_EN selects exponential release instead of linear.
module adsr_poly #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VOICES-1:0]       gate,
  input  logic [ACC_W-1:0]            attack_step,
  input  logic [ACC_W-1:0]            decay_step,
  input  logic [ACC_W-1:0]            sustain_level,
  input  logic [ACC_W-1:0]            release_step,
  output logic [NUM_VOICES*OUT_W-1:0] envelope,
  output logic [NUM_VOICES-1:0]       voice_idle,
  output logic                        all_idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  localparam logic [ACC_W-1:0] MAX     = ACC_W'(1) << (ACC_W - 1);
  localparam logic [OUT_W-2:0] MAX_TOP = MAX[ACC_W-1 -: OUT_W-1];

  state_t                      state_q [NUM_VOICES];
  state_t                      state_d [NUM_VOICES];
  logic [ACC_W-1:0]            amp_q   [NUM_VOICES];
  logic [ACC_W-1:0]            amp_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0]       gate_dly_q, gate_dly_d;
  logic [NUM_VOICES*OUT_W-1:0] env_q, env_d;
  logic [NUM_VOICES-1:0]       idle_q, idle_d;
  logic                        all_idle_q, all_idle_d;

  logic [ACC_W-1:0] sus_clamped;
  logic             bypass;
  logic             mute;
  logic             rise;
  logic             fall;
  logic [ACC_W:0]   sum;
`ifdef ADSR_EXP_RELEASE_EN
  logic [ACC_W-1:0] dec_exp;
  logic             exp_unused;
  // Only the shift amount of release_step matters in exponential mode.
  assign exp_unused = ^release_step[ACC_W-1:5];
`endif

  // Per-voice next-state, amplitude and output mapping.
  always_comb begin
    sus_clamped = (sustain_level > MAX) ? MAX : sustain_level;
    bypass      = &attack_step;
    mute        = ~|attack_step;
    gate_dly_d  = gate;
    env_d       = '0;
    idle_d      = '0;
    rise        = 1'b0;
    fall        = 1'b0;
    sum         = '0;
`ifdef ADSR_EXP_RELEASE_EN
    dec_exp     = '0;
`endif
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      state_d[v] = state_q[v];
      amp_d[v]   = amp_q[v];
      rise       = gate[v] & ~gate_dly_q[v];
      fall       = ~gate[v] & gate_dly_q[v];
      sum        = {1'b0, amp_q[v]} + {1'b0, attack_step};
`ifdef ADSR_EXP_RELEASE_EN
      dec_exp    = (amp_q[v] >> release_step[4:0]) + ACC_W'(1);
`endif
      case (state_q[v])
        S_IDLE: begin
          if (rise) begin
            state_d[v] = S_ATTACK;
            amp_d[v]   = '0;
          end
        end
        S_ATTACK: begin
          if (fall) begin
            state_d[v] = S_RELEASE;
          end else if (sum >= {1'b0, MAX}) begin
            amp_d[v]   = MAX;
            state_d[v] = S_DECAY;
          end else begin
            amp_d[v] = sum[ACC_W-1:0];
          end
        end
        S_DECAY: begin
          if (fall) begin
            state_d[v] = S_RELEASE;
          end else if ((amp_q[v] <= decay_step) ||
                       ((amp_q[v] - decay_step) <= sus_clamped)) begin
            amp_d[v]   = sus_clamped;
            state_d[v] = S_SUSTAIN;
          end else begin
            amp_d[v] = amp_q[v] - decay_step;
          end
        end
        S_SUSTAIN: begin
          if (fall) state_d[v] = S_RELEASE;
          else      amp_d[v]   = sus_clamped;
        end
        S_RELEASE: begin
          // Retrigger keeps the current amplitude so there is no click.
          if (rise) begin
            state_d[v] = S_ATTACK;
`ifdef ADSR_EXP_RELEASE_EN
          end else if (amp_q[v] > dec_exp) begin
            amp_d[v] = amp_q[v] - dec_exp;
`else
          end else if (amp_q[v] > release_step) begin
            amp_d[v] = amp_q[v] - release_step;
`endif
          end else begin
            amp_d[v]   = '0;
            state_d[v] = S_IDLE;
          end
        end
        default: begin
          state_d[v] = S_IDLE;
          amp_d[v]   = '0;
        end
      endcase
      idle_d[v] = (state_d[v] == S_IDLE);
      env_d[v*OUT_W +: OUT_W] = {1'b0, bypass ? MAX_TOP :
                                       mute   ? '0      :
                                                amp_q[v][ACC_W-1 -: OUT_W-1]};
    end
    all_idle_d = &idle_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        state_q[v] <= S_IDLE;
        amp_q[v]   <= '0;
      end
      gate_dly_q <= '0;
      env_q      <= '0;
      idle_q     <= '1;
      all_idle_q <= 1'b1;
    end else begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        state_q[v] <= state_d[v];
        amp_q[v]   <= amp_d[v];
      end
      gate_dly_q <= gate_dly_d;
      env_q      <= env_d;
      idle_q     <= idle_d;
      all_idle_q <= all_idle_d;
    end
  end

  assign envelope   = env_q;
  assign voice_idle = idle_q;
  assign all_idle   = all_idle_q;

endmodule

// File: tb/tb_adsr_poly.sv
// Bench for adsr_poly: directed scenarios plus random gates/settings against an arithmetic model.
module tb_adsr_poly;

  localparam int unsigned NV    = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 16;
  localparam longint      MAXL  = 64'sh8000_0000;
  localparam int          SHIFT = ACC_W - (OUT_W - 1);

  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NV-1:0]          gate;
  logic [ACC_W-1:0]       attack_step, decay_step, sustain_level, release_step;
  logic [NV*OUT_W-1:0]    envelope;
  logic [NV-1:0]          voice_idle;
  logic                   all_idle;

  int vectors = 0;
  int miscompares = 0;

  int          m_st  [NV];
  longint      m_amp [NV];
  bit          m_gd  [NV];
  logic [63:0] exp_env;
  logic [NV-1:0] exp_idle;

  adsr_poly #(.NUM_VOICES(NV), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .envelope     (envelope),
    .voice_idle   (voice_idle),
    .all_idle     (all_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] env_of(input longint amp, input longint atk);
    longint v;
    if (atk == 64'hFFFF_FFFF) v = MAXL;
    else if (atk == 0)        v = 0;
    else                      v = amp;
    return 16'((v >> SHIFT) & 64'h7FFF);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_st[v] = P_IDLE; m_amp[v] = 0; m_gd[v] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the current inputs, then compare after the edge.
  task automatic tick();
    longint atk, dcy, sus, rel, d;
    bit g, rise, fall;
    atk = longint'(attack_step);
    dcy = longint'(decay_step);
    sus = longint'(sustain_level);
    rel = longint'(release_step);
    if (sus > MAXL) sus = MAXL;
    if (reset) begin
      model_reset();
      exp_env  = '0;
      exp_idle = '1;
    end else begin
      for (int v = 0; v < NV; v++) begin
        exp_env[v*16 +: 16] = env_of(m_amp[v], atk);
        g    = gate[v];
        rise = g && !m_gd[v];
        fall = !g && m_gd[v];
        case (m_st[v])
          P_IDLE: if (rise) begin m_st[v] = P_ATK; m_amp[v] = 0; end
          P_ATK: begin
            if (fall) m_st[v] = P_REL;
            else if (m_amp[v] + atk >= MAXL) begin m_amp[v] = MAXL; m_st[v] = P_DEC; end
            else m_amp[v] = m_amp[v] + atk;
          end
          P_DEC: begin
            if (fall) m_st[v] = P_REL;
            else if (m_amp[v] <= dcy || m_amp[v] - dcy <= sus) begin
              m_amp[v] = sus; m_st[v] = P_SUS;
            end else m_amp[v] = m_amp[v] - dcy;
          end
          P_SUS: begin
            if (fall) m_st[v] = P_REL;
            else m_amp[v] = sus;
          end
          default: begin
            if (rise) m_st[v] = P_ATK;
            else begin
`ifdef ADSR_EXP_RELEASE_EN
              d = (m_amp[v] >> (rel % 32)) + 1;
`else
              d = rel;
`endif
              if (m_amp[v] > d) m_amp[v] = m_amp[v] - d;
              else begin m_amp[v] = 0; m_st[v] = P_IDLE; end
            end
          end
        endcase
        m_gd[v] = g;
        exp_idle[v] = (m_st[v] == P_IDLE);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("envelope", 64'(envelope), exp_env);
    check("voice_idle", 64'(voice_idle), 64'(exp_idle));
    check("all_idle", 64'(all_idle), 64'(&exp_idle));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_all_idle(input string tag);
    int n = 0;
    while (!all_idle && n < 300) begin tick(); n++; end
    check(tag, 64'(all_idle), 64'd1);
  endtask

  function automatic logic [31:0] rnd_step();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 255));
      3: return 32'($urandom) >> $urandom_range(2, 10);
      4: return 32'h8000_0000;
      5: return 32'($urandom) >> 4;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; gate = '0;
    attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_envelope", 64'(envelope), 64'd0);
    check("rst_voice_idle", 64'(voice_idle), 64'hF);
    check("rst_all_idle", 64'(all_idle), 64'd1);

    reset = 1'b0;
    attack_step = 32'h2000_0000; decay_step = 32'h1000_0000;
    sustain_level = 32'h6000_0000; release_step = 32'h2000_0000;
    tick();

    // Attack, decay into sustain on voice 0.
    gate = 4'b0001;
    ticks(6);
    check("peak_env", 64'(envelope[15:0]), 64'h4000);
    check("busy_idle0", 64'(voice_idle[0]), 64'd0);
    ticks(2);
    check("sustain_env", 64'(envelope[15:0]), 64'h3000);

    // Linear release to idle.
    gate = 4'b0000;
    ticks(3);
    check("rel_not_idle", 64'(voice_idle[0]), 64'd0);
    tick();
    check("rel_idle", 64'(voice_idle[0]), 64'd1);

    // Legato retrigger from release at 0x4000_0000.
    gate = 4'b0001;
    ticks(8);
    gate = 4'b0000;
    ticks(2);
    gate = 4'b0001;
    tick();
    check("legato_hold", 64'(envelope[15:0]), 64'h2000);
    ticks(2);
    check("legato_rise", 64'(envelope[15:0]), 64'h3000);
    check("others_idle", 64'(voice_idle[3:1]), 64'h7);

    // Bypass and mute force all outputs regardless of state.
    attack_step = 32'hFFFF_FFFF;
    tick();
    check("bypass_env", 64'(envelope), 64'h4000_4000_4000_4000);
    attack_step = 32'h0;
    tick();
    check("mute_env", 64'(envelope), 64'h0);
    attack_step = 32'h2000_0000;
    gate = 4'b0000;
    wait_all_idle("idle_after_mute");

    // Staggered release across all voices.
    gate = 4'b1111;
    ticks(10);
    gate = 4'b1110; ticks(3);
    gate = 4'b1100; ticks(3);
    gate = 4'b0000;
    wait_all_idle("stagger_idle");

`ifdef ADSR_EXP_RELEASE_EN
    sustain_level = 32'hFFFF_FFFF;
    release_step = 32'h0000_0001;
    gate = 4'b0001;
    ticks(10);
    gate = 4'b0000;
    wait_all_idle("exp_release_idle");
    sustain_level = 32'h6000_0000;
`endif

    // Random gates and settings, with occasional asynchronous reset mid-note.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) gate[$urandom_range(0, NV-1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        attack_step   = rnd_step();
        decay_step    = rnd_step();
        sustain_level = ($urandom_range(0, 4) == 0) ? 32'hC000_0000 : 32'($urandom) >> 1;
        release_step  = rnd_step();
        if (attack_step == 0 && $urandom_range(0, 1) == 0) attack_step = 32'h0100_0000;
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        #1;
        check("async_rst_env", 64'(envelope), 64'd0);
        check("async_rst_idle", 64'(voice_idle), 64'hF);
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
